// File: rtl/mips_rf_pkg.sv
// Shared register-file geometry and the writeback entry carried through the write queue.
package mips_rf_pkg;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = $clog2(NUM_REGS);
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] regnum;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;
endpackage

// File: rtl/rf_write_queue_if.sv
// Producer handshake, register-file write port and forwarding lookups of the write queue.
interface rf_write_queue_if
  import mips_rf_pkg::*;
();
  logic                  in_valid;
  logic                  in_ready;
  logic [REG_ADDR_W-1:0] in_reg;
  logic [DATA_W-1:0]     in_data;
  logic                  rf_rw;
  logic [REG_ADDR_W-1:0] rf_writereg;
  logic [DATA_W-1:0]     rf_datawritten;
  logic [REG_ADDR_W-1:0] fwd1_reg;
  logic                  fwd1_hit;
  logic [DATA_W-1:0]     fwd1_data;
  logic [REG_ADDR_W-1:0] fwd2_reg;
  logic                  fwd2_hit;
  logic [DATA_W-1:0]     fwd2_data;
  logic                  idle;

  modport slave (
    input  in_valid, in_reg, in_data, fwd1_reg, fwd2_reg,
    output in_ready, rf_rw, rf_writereg, rf_datawritten,
           fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, idle
  );

  modport master (
    output in_valid, in_reg, in_data, fwd1_reg, fwd2_reg,
    input  in_ready, rf_rw, rf_writereg, rf_datawritten,
           fwd1_hit, fwd1_data, fwd2_hit, fwd2_data, idle
  );
endinterface

// File: rtl/rf_fwd_match.sv
// One forwarding lookup: priority search over age-ordered entries, highest index is newest.
module rf_fwd_match
  import mips_rf_pkg::*;
#(
  parameter int N       = 5,
  parameter int DROP_R0 = 0
) (
  input  wb_entry_t [N-1:0]       entries,
  input  logic [N-1:0]            valid,
  input  logic [REG_ADDR_W-1:0]   lookup,
  output logic                    hit,
  output logic [DATA_W-1:0]       data
);

  // NOTE: blocking assignments in combinational logic; later loop iterations
  // overwrite earlier ones, which is exactly what gives the newest entry priority.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < N; i++) begin
      if (valid[i] && entries[i].regnum == lookup) begin
        hit  = 1'b1;
        data = entries[i].data;
      end
    end
    if (DROP_R0 != 0 && lookup == '0) begin
      hit  = 1'b0;
      data = '0;
    end
  end

endmodule

// File: rtl/rf_write_queue.sv
// In-order writeback queue draining one entry per cycle onto the register file write port,
// with two forwarding lookups covering every write not yet committed.
module rf_write_queue
  import mips_rf_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter int  DROP_R0 = 0,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  rf_write_queue_if.slave   bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int NSRC  = DEPTH + 1;

  wb_entry_t          mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               out_valid;
  wb_entry_t          out_entry;

  logic               stall;
  logic               accept;
  logic               push;
  logic               pop;

  // Hold point for the write port; tied off in normal use so the queue always drains.
  assign stall  = 1'b0;
  assign accept = bus.in_valid && bus.in_ready;
  assign push   = accept && !(DROP_R0 != 0 && bus.in_reg == '0);
  assign pop    = (count != '0) && !stall;

  // NOTE: non-blocking assignments for all state, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_entry <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      out_valid <= pop;
      if (pop) out_entry <= mem[rd_ptr];
    end
  end

  // NOTE: storage is not reset; count and out_valid gate every use, so stale slots are never seen.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{regnum: bus.in_reg, data: bus.in_data};
  end

  // Age-ordered search set: output register first, then head through tail.
  wb_entry_t [NSRC-1:0] src;
  logic [NSRC-1:0]      src_valid;

  always_comb begin
    src          = '0;
    src_valid    = '0;
    src[0]       = out_entry;
    src_valid[0] = out_valid;
    for (int i = 0; i < DEPTH; i++) begin
      src[i+1]       = mem[rd_ptr + PTR_W'(i)];
      src_valid[i+1] = CNT_W'(i) < count;
    end
  end

  rf_fwd_match #(.N(NSRC), .DROP_R0(DROP_R0)) u_fwd1 (
    .entries (src),
    .valid   (src_valid),
    .lookup  (bus.fwd1_reg),
    .hit     (bus.fwd1_hit),
    .data    (bus.fwd1_data)
  );

  rf_fwd_match #(.N(NSRC), .DROP_R0(DROP_R0)) u_fwd2 (
    .entries (src),
    .valid   (src_valid),
    .lookup  (bus.fwd2_reg),
    .hit     (bus.fwd2_hit),
    .data    (bus.fwd2_data)
  );

  assign bus.in_ready       = count != CNT_W'(DEPTH);
  assign bus.rf_rw          = out_valid;
  assign bus.rf_writereg    = out_entry.regnum;
  assign bus.rf_datawritten = out_entry.data;
  assign bus.idle           = (count == '0) && !out_valid;

endmodule

// File: tb/tb_rf_write_queue.sv
// Directed bench: one queue with register 0 ordinary, one with register 0 dropped,
// each with a negedge-committing register file model and write log.
module tb_rf_write_queue;
  import mips_rf_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_compared   = 0;
  int   n_mismatched = 0;

  always #5 clk = ~clk;

  rf_write_queue_if bus0 ();
  rf_write_queue_if bus1 ();

  rf_write_queue #(.DEPTH(4), .DROP_R0(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  rf_write_queue #(.DEPTH(4), .DROP_R0(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic [36:0] log0[$];
  logic [36:0] log1[$];
  logic [31:0] rf_model0 [NUM_REGS];

  always @(negedge clk) begin
    if (bus0.rf_rw === 1'b1) begin
      rf_model0[bus0.rf_writereg] = bus0.rf_datawritten;
      log0.push_back({bus0.rf_writereg, bus0.rf_datawritten});
    end
    if (bus1.rf_rw === 1'b1) log1.push_back({bus1.rf_writereg, bus1.rf_datawritten});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    assert (obs === exp)
    else begin
      n_mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive0(input logic v, input logic [4:0] r, input logic [31:0] d);
    bus0.in_valid = v;
    bus0.in_reg   = r;
    bus0.in_data  = d;
  endtask

  task automatic drive1(input logic v, input logic [4:0] r, input logic [31:0] d);
    bus1.in_valid = v;
    bus1.in_reg   = r;
    bus1.in_data  = d;
  endtask

  initial begin
    int n_before;
    for (int i = 0; i < NUM_REGS; i++) rf_model0[i] = '0;
    drive0(1'b0, 5'd0, 32'h0);
    drive1(1'b0, 5'd0, 32'h0);
    bus0.fwd1_reg = 5'd0;
    bus0.fwd2_reg = 5'd0;
    bus1.fwd1_reg = 5'd0;
    bus1.fwd2_reg = 5'd0;

    // Reset state
    #12;
    check("rst_rw", bus0.rf_rw, 1'b0);
    check("rst_writereg", bus0.rf_writereg, 5'd0);
    check("rst_data", bus0.rf_datawritten, 32'h0);
    check("rst_in_ready", bus0.in_ready, 1'b1);
    check("rst_idle", bus0.idle, 1'b1);
    check("rst_fwd1_hit", bus0.fwd1_hit, 1'b0);
    check("rst_fwd1_data", bus0.fwd1_data, 32'h0);
    check("rst_fwd2_hit", bus0.fwd2_hit, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Three back-to-back pushes, one-cycle latency, FIFO order
    drive0(1'b1, 5'd3, 32'h11);
    tick();
    check("t1_no_passthrough", bus0.rf_rw, 1'b0);
    drive0(1'b1, 5'd7, 32'h22);
    tick();
    check("t1_w0", {bus0.rf_rw, bus0.rf_writereg, bus0.rf_datawritten}, {1'b1, 5'd3, 32'h11});
    drive0(1'b1, 5'd3, 32'h33);
    tick();
    check("t1_w1", {bus0.rf_rw, bus0.rf_writereg, bus0.rf_datawritten}, {1'b1, 5'd7, 32'h22});
    drive0(1'b0, 5'd0, 32'h0);
    tick();
    check("t1_w2", {bus0.rf_rw, bus0.rf_writereg, bus0.rf_datawritten}, {1'b1, 5'd3, 32'h33});
    tick();
    check("t1_rw_off", bus0.rf_rw, 1'b0);
    check("t1_idle", bus0.idle, 1'b1);
    check("t1_r3", rf_model0[3], 32'h33);
    check("t1_r7", rf_model0[7], 32'h22);

    // Sustained throughput: six consecutive pushes with the queue always draining
    log0.delete();
    for (int i = 0; i < 6; i++) begin
      drive0(1'b1, 5'(i + 1), 32'h100 + 32'(i));
      check($sformatf("t2_ready%0d", i), bus0.in_ready, 1'b1);
      tick();
    end
    drive0(1'b0, 5'd0, 32'h0);
    check("t2_busy0", bus0.idle, 1'b0);
    tick();
    check("t2_busy1", bus0.idle, 1'b0);
    tick();
    check("t2_idle", bus0.idle, 1'b1);
    tick();
    check("t2_count", log0.size(), 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("t2_log%0d", i), log0[i], {5'(i + 1), 32'h100 + 32'(i)});

    // Full: stall the write port, fill four slots, hold the fifth
    log0.delete();
    force dut0.stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive0(1'b1, 5'(10 + i), 32'h20 + 32'(i));
      tick();
    end
    drive0(1'b1, 5'd14, 32'h24);
    check("t3_full_ready", bus0.in_ready, 1'b0);
    check("t3_full_rw", bus0.rf_rw, 1'b0);
    tick();
    check("t3_held_ready", bus0.in_ready, 1'b0);
    release dut0.stall;
    tick();
    check("t3_free_ready", bus0.in_ready, 1'b1);
    check("t3_first_out", {bus0.rf_rw, bus0.rf_writereg}, {1'b1, 5'd10});
    tick();
    drive0(1'b0, 5'd0, 32'h0);
    check("t3_second_out", {bus0.rf_rw, bus0.rf_writereg}, {1'b1, 5'd11});
    tick(6);
    check("t3_count", log0.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("t3_log%0d", i), log0[i], {5'(10 + i), 32'h20 + 32'(i)});

    // Forwarding: newest match wins, output register included, incoming entry excluded
    force dut0.stall = 1'b1;
    drive0(1'b1, 5'd5, 32'hA);
    tick();
    drive0(1'b1, 5'd5, 32'hB);
    tick();
    drive0(1'b1, 5'd9, 32'hC);
    tick();
    drive0(1'b0, 5'd0, 32'h0);
    bus0.fwd1_reg = 5'd5;
    bus0.fwd2_reg = 5'd9;
    #1;
    check("t4_f1", {bus0.fwd1_hit, bus0.fwd1_data}, {1'b1, 32'hB});
    check("t4_f2", {bus0.fwd2_hit, bus0.fwd2_data}, {1'b1, 32'hC});
    bus0.fwd1_reg = 5'd6;
    drive0(1'b1, 5'd6, 32'hD);
    #1;
    check("t4_miss_incoming", {bus0.fwd1_hit, bus0.fwd1_data}, {1'b0, 32'h0});
    drive0(1'b0, 5'd0, 32'h0);
    bus0.fwd1_reg = 5'd5;
    release dut0.stall;
    tick();
    check("t4_f1_out_a", {bus0.fwd1_hit, bus0.fwd1_data}, {1'b1, 32'hB});
    tick();
    check("t4_f1_out_b", {bus0.fwd1_hit, bus0.fwd1_data}, {1'b1, 32'hB});
    tick();
    check("t4_f1_gone", {bus0.fwd1_hit, bus0.fwd1_data}, {1'b0, 32'h0});
    check("t4_f2_out", {bus0.fwd2_hit, bus0.fwd2_data}, {1'b1, 32'hC});
    tick();
    check("t4_f2_gone", bus0.fwd2_hit, 1'b0);

    // Register 0: ordinary on dut0, dropped on dut1
    drive0(1'b1, 5'd0, 32'h55);
    tick();
    drive0(1'b0, 5'd0, 32'h0);
    bus0.fwd1_reg = 5'd0;
    #1;
    check("t5_r0_fwd", {bus0.fwd1_hit, bus0.fwd1_data}, {1'b1, 32'h55});
    tick(2);
    check("t5_r0_written", rf_model0[0], 32'h55);

    drive1(1'b1, 5'd0, 32'hFF);
    tick();
    check("t5_drop_idle", bus1.idle, 1'b1);
    check("t5_drop_ready", bus1.in_ready, 1'b1);
    drive1(1'b1, 5'd1, 32'h1);
    tick();
    drive1(1'b0, 5'd0, 32'h0);
    bus1.fwd1_reg = 5'd0;
    bus1.fwd2_reg = 5'd1;
    #1;
    check("t5_drop_fwd0", {bus1.fwd1_hit, bus1.fwd1_data}, {1'b0, 32'h0});
    check("t5_drop_fwd1", {bus1.fwd2_hit, bus1.fwd2_data}, {1'b1, 32'h1});
    tick(3);
    check("t5_drop_count", log1.size(), 1);
    check("t5_drop_log", log1[0], {5'd1, 32'h1});

    // Reset with work pending and a write on the port
    force dut0.stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive0(1'b1, 5'(20 + i), 32'h40 + 32'(i));
      tick();
    end
    drive0(1'b0, 5'd0, 32'h0);
    bus0.fwd1_reg = 5'd21;
    release dut0.stall;
    tick();
    check("t6_pre_rw", bus0.rf_rw, 1'b1);
    n_before = log0.size();
    rst = 1'b1;
    #1;
    check("t6_rw", bus0.rf_rw, 1'b0);
    check("t6_idle", bus0.idle, 1'b1);
    check("t6_ready", bus0.in_ready, 1'b1);
    check("t6_writereg", bus0.rf_writereg, 5'd0);
    check("t6_fwd", bus0.fwd1_hit, 1'b0);
    tick(2);
    @(negedge clk);
    rst = 1'b0;
    tick(6);
    check("t6_no_writes", log0.size(), n_before);
    check("t6_idle_after", bus0.idle, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/rf_write_queue.md
Name: rf_write_queue

Overview:
- Write-side initiator for the MIPS register file. It collects writeback results from the execute/memory stages through a valid/ready handshake and buffers them in a small in-order queue.
- It drains one entry per cycle onto the register file's single write port (rw, writereg, datawritten). The register file commits on negedge clk.
- It provides two forwarding lookup ports that mirror the register file's two read ports, so readers see results that are still pending.

Parameters:
- DEPTH, 4, queue entries; power of two, >= 2
- DROP_R0, 0, 1 = discard writes to register 0 and never forward register 0; 0 = register 0 is an ordinary register
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

Ports:
- clk  in  1  system clock; all state changes on posedge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  producer has a result
- in_ready  out  1  queue can accept; equals (count != DEPTH)
- in_reg  in  5  destination register
- in_data  in  32  result value
- rf_rw  out  1  write strobe to register file (its rw)
- rf_writereg  out  5  to register file writereg
- rf_datawritten  out  32  to register file datawritten
- fwd1_reg  in  5  lookup address (driven with redreg1)
- fwd1_hit  out  1  a pending write to fwd1_reg exists
- fwd1_data  out  32  newest pending value for fwd1_reg; 0 when no hit
- fwd2_reg, fwd2_hit, fwd2_data  same as fwd1, for redreg2
- idle  out  1  count == 0 and rf_rw == 0

Behaviour:
- Reset (async, immediate):
  - count = 0, read and write pointers = 0
  - rf_rw = 0, rf_writereg = 0, rf_datawritten = 0
  - in_ready = 1, idle = 1, fwd*_hit = 0, fwd*_data = 0
  - Reset mid-operation discards all pending entries, including the one on the output registers; no register-file write may occur after rst rises.
- Accept: a push happens at posedge when in_valid && in_ready. With DROP_R0=1 and in_reg==0, the handshake completes but nothing is enqueued.
- Drain: at each posedge, if count != 0, the head entry moves to the output registers and rf_rw = 1; otherwise rf_rw = 0. Outputs are registered and therefore stable across the negedge commit.
- Latency: accepted at posedge k -> presented at posedge k+1 -> committed at the following negedge. Each entry asserts rf_rw for exactly one cycle.
- Sustained throughput is 1 write per cycle.
- Simultaneous push and pop: count is unchanged. Push when full is impossible because in_ready = 0. Push into an empty queue follows the same 1-cycle path as any other entry; there is no same-cycle passthrough.
- Ordering: strictly FIFO. Repeated writes to the same register all commit, in order.
- Pointers wrap modulo DEPTH; count is the sole full/empty source.
- Forwarding (combinational):
  - Search set = the output-register entry (if rf_rw) plus all valid queue entries.
  - The newest match wins; age order is output register < head ... < tail.
  - The incoming in_* entry is not searched.
  - With DROP_R0=1, a lookup of register 0 never hits.

Decomposition:
- Package mips_rf_pkg: REG_ADDR_W=5, DATA_W=32, NUM_REGS=32, and a wb_entry struct {reg, data}.
- Sub-module rf_fwd_match: one lookup port's priority search over the entry array and valid mask. It is instantiated twice.

Test Plan:
- Push (3,0x11), (7,0x22), (3,0x33) on consecutive cycles -> rf_rw high for 3 consecutive cycles starting one cycle after the first push, with writereg/data 3/0x11, 7/0x22, 3/0x33; register 3 ends at 0x33.
- Hold in_valid for 6 cycles with a sink that always drains, DEPTH=4 -> in_ready never drops; 6 writes in order; idle returns 1 two cycles after the last push.
- Push 4 entries in one burst while the drain is forced (via injected stall) to show full -> in_ready=0 at count 4; the 5th is held by the producer and accepted when a slot frees; no loss or duplication.
- Queue holds (5,0xA), (5,0xB), (9,0xC); fwd1_reg=5, fwd2_reg=9 -> fwd1_hit=1, data 0xB; fwd2_hit=1, data 0xC; fwd1_reg=6 -> hit=0, data 0.
- DROP_R0=1: push (0,0xFF) then (1,0x1) -> only register 1 is written; fwd lookup of 0 gives hit=0.
- Assert rst with 3 entries pending and rf_rw=1 -> rf_rw drops immediately; count=0; no further writes; in_ready=1.
